regfile_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 32 x 32 register file. It merges two write-back requesters onto the register file's single write port: ALU results (A) and memory load results (M). It also tracks which registers have a write in flight and stalls issue on read-after-write (RAW) or write-after-write (WAW) hazards. It sits between the execute/memory stages and the register file write port (RegWr/RD/WData), and between decode and issue.

---
 rtl/regfile_wb_arbiter_if.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 87 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - write-back, issue and register-file port bundle for regfile_wb_arbiter
interface regfile_wb_arbiter_if;
    logic        AValid;
    logic [4:0]  ARd;
    logic [31:0] AData;
    logic        AReady;
    logic        MValid;
    logic [4:0]  MRd;
    logic [31:0] MData;
    logic        MReady;
    logic        IssueValid;
    logic [4:0]  IssueRs1;
    logic [4:0]  IssueRs2;
    logic [4:0]  IssueRd;
    logic        IssueWritesRd;
    logic        Stall;
    logic        RegWr;
    logic [4:0]  RD;
    logic [31:0] WData;
    logic [31:0] Pending;

    modport master (
        output AValid, ARd, AData, MValid, MRd, MData,
               IssueValid, IssueRs1, IssueRs2, IssueRd, IssueWritesRd,
        input  AReady, MReady, Stall, RegWr, RD, WData, Pending
    );

    modport slave (
        input  AValid, ARd, AData, MValid, MRd, MData,
               IssueValid, IssueRs1, IssueRs2, IssueRd, IssueWritesRd,
        output AReady, MReady, Stall, RegWr, RD, WData, Pending
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-back arbiter and RAW/WAW scoreboard for the 32x32 register file
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input logic                 Clk,
    input logic                 Reset_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  starve_cnt;
    logic        a_prio;
    logic        a_ready;
    logic        m_ready;
    logic        any_acc;
    logic [4:0]  win_rd;
    logic [31:0] win_data;
    logic        stall;
    logic        issue_acc;
    logic        reg_wr_q;
    logic [4:0]  rd_q;
    logic [31:0] wdata_q;
    logic [31:0] pending_q;
    logic [31:0] pending_d;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    // Readies and Stall are forced low while reset is held, independent of the clock.
    always_comb begin
        a_prio   = (starve_cnt == LIMIT);
        a_ready  = Reset_n & bus.AValid & (a_prio | ~bus.MValid);
        m_ready  = Reset_n & bus.MValid & ~a_ready;
        any_acc  = a_ready | m_ready;
        win_rd   = a_ready ? bus.ARd : bus.MRd;
        win_data = a_ready ? bus.AData : bus.MData;

        stall = Reset_n & bus.IssueValid &
                (pending_q[bus.IssueRs1] | pending_q[bus.IssueRs2] |
                 (bus.IssueWritesRd & pending_q[bus.IssueRd]));
        issue_acc = bus.IssueValid & ~stall & bus.IssueWritesRd & (bus.IssueRd != 5'd0);

        set_mask = issue_acc ? (32'd1 << bus.IssueRd) : 32'd0;
        clr_mask = reg_wr_q ? (32'd1 << rd_q) : 32'd0;
        // Set is applied after clear so a same-edge collision leaves the bit set.
        pending_d = ((pending_q & ~clr_mask) | set_mask) & ~32'd1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            starve_cnt <= 4'd0;
        end else if (!bus.AValid || a_ready) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            reg_wr_q <= 1'b0;
            rd_q     <= 5'd0;
            wdata_q  <= 32'd0;
        end else if (any_acc) begin
            reg_wr_q <= (win_rd != 5'd0);
            rd_q     <= win_rd;
            wdata_q  <= win_data;
        end else begin
            reg_wr_q <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pending_q <= 32'd0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign bus.AReady  = a_ready;
    assign bus.MReady  = m_ready;
    assign bus.Stall   = stall;
    assign bus.RegWr   = reg_wr_q;
    assign bus.RD      = rd_q;
    assign bus.WData   = wdata_q;
    assign bus.Pending = pending_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - vector table and write-port scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int STARVE_LIMIT = 3;

    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        iv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  ird;
        logic        iw;
        logic        e_ar;
        logic        e_mr;
        logic        e_st;
        logic [31:0] e_pend;
    } vec_t;

    typedef struct {
        logic        wr;
        logic        chk_addr;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    vec_t vecs[$];
    wb_t  sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
        input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [4:0] ird, input logic iw,
        input logic e_ar, input logic e_mr, input logic e_st, input logic [31:0] e_pend);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad;
        v.mv = mv; v.mrd = mrd; v.md = md;
        v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.ird = ird; v.iw = iw;
        v.e_ar = e_ar; v.e_mr = e_mr; v.e_st = e_st; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.AValid = v.av;  bus.ARd = v.ard; bus.AData = v.ad;
        bus.MValid = v.mv;  bus.MRd = v.mrd; bus.MData = v.md;
        bus.IssueValid = v.iv; bus.IssueRs1 = v.rs1; bus.IssueRs2 = v.rs2;
        bus.IssueRd = v.ird;   bus.IssueWritesRd = v.iw;
    endtask

    task automatic pop_check(input int idx);
        wb_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk($sformatf("v%0d RegWr", idx), {31'd0, bus.RegWr}, {31'd0, e.wr});
        if (e.chk_addr) begin
            chk($sformatf("v%0d RD", idx), {27'd0, bus.RD}, {27'd0, e.rd});
            chk($sformatf("v%0d WData", idx), bus.WData, e.data);
        end
    endtask

    task automatic push_expect(input vec_t v);
        wb_t e;
        if (v.e_ar) begin
            e.wr = (v.ard != 5'd0); e.chk_addr = 1'b1; e.rd = v.ard; e.data = v.ad;
        end else if (v.e_mr) begin
            e.wr = (v.mrd != 5'd0); e.chk_addr = 1'b1; e.rd = v.mrd; e.data = v.md;
        end else begin
            e.wr = 1'b0; e.chk_addr = 1'b0; e.rd = 5'd0; e.data = 32'd0;
        end
        sb.push_back(e);
    endtask

    localparam logic [31:0] AD = 32'hA1A1_0001;

    initial begin
        vec_t idle;
        idle = mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0);

        // single write, then idle
        vecs.push_back(mk(1,5,32'hDEADBEEF, 0,0,0, 0,0,0,0,0, 1,0,0,32'h0));
        vecs.push_back(idle);
        vecs.push_back(idle);
        // contention: M holds its request while denied
        vecs.push_back(mk(1,1,AD, 1,2,32'h0200, 0,0,0,0,0, 0,1,0,32'h0));
        vecs.push_back(mk(1,1,AD, 1,3,32'h0300, 0,0,0,0,0, 0,1,0,32'h0));
        vecs.push_back(mk(1,1,AD, 1,4,32'h0400, 0,0,0,0,0, 0,1,0,32'h0));
        vecs.push_back(mk(1,1,AD, 1,5,32'h0500, 0,0,0,0,0, 1,0,0,32'h0));
        vecs.push_back(mk(1,1,AD, 1,5,32'h0500, 0,0,0,0,0, 0,1,0,32'h0));
        vecs.push_back(mk(1,1,AD, 1,6,32'h0600, 0,0,0,0,0, 0,1,0,32'h0));
        vecs.push_back(mk(1,1,AD, 1,7,32'h0700, 0,0,0,0,0, 0,1,0,32'h0));
        vecs.push_back(mk(1,1,AD, 1,8,32'h0800, 0,0,0,0,0, 1,0,0,32'h0));
        vecs.push_back(idle);
        // RAW on r7
        vecs.push_back(mk(0,0,0, 0,0,0, 1,0,0,7,1, 0,0,0,32'h0));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,7,0,10,1, 0,0,1,32'h80));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,7,0,10,1, 0,0,1,32'h80));
        vecs.push_back(mk(0,0,0, 1,7,32'h77, 1,7,0,10,1, 0,1,1,32'h80));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,7,0,10,1, 0,0,1,32'h80));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,7,0,10,1, 0,0,0,32'h0));
        vecs.push_back(idle);
        vecs[$].e_pend = 32'h400;
        // r0 request and r0 issue
        vecs.push_back(mk(1,0,32'h1234, 0,0,0, 1,0,0,0,1, 1,0,0,32'h400));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,32'h400));
        // set/clear collision on r9
        vecs.push_back(mk(0,0,0, 1,9,32'h99, 0,0,0,0,0, 0,1,0,32'h400));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,0,0,9,1, 0,0,0,32'h400));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,0,0,9,1, 0,0,1,32'h600));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,0,0,9,0, 0,0,0,32'h600));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,0,10,0,0, 0,0,1,32'h600));
        vecs.push_back(mk(1,10,32'h10, 0,0,0, 0,0,0,0,0, 1,0,0,32'h600));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,9,9,9,1, 0,0,0,32'h600));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,32'h200));

        // reset state, with live requests to check output gating
        Reset_n = 1'b0;
        drive(mk(1,3,32'h3, 1,4,32'h4, 1,1,2,3,1, 0,0,0,0));
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst RegWr", {31'd0, bus.RegWr}, 32'd0);
        chk("rst RD", {27'd0, bus.RD}, 32'd0);
        chk("rst WData", bus.WData, 32'd0);
        chk("rst Pending", bus.Pending, 32'd0);
        chk("rst ready/stall", {29'd0, bus.AReady, bus.MReady, bus.Stall}, 32'd0);
        @(posedge Clk);
        #1 drive(idle);
        Reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge Clk);
            #1 drive(vecs[i]);
            @(negedge Clk);
            pop_check(i);
            chk($sformatf("v%0d AReady", i), {31'd0, bus.AReady}, {31'd0, vecs[i].e_ar});
            chk($sformatf("v%0d MReady", i), {31'd0, bus.MReady}, {31'd0, vecs[i].e_mr});
            chk($sformatf("v%0d Stall", i), {31'd0, bus.Stall}, {31'd0, vecs[i].e_st});
            chk($sformatf("v%0d Pending", i), bus.Pending, vecs[i].e_pend);
            push_expect(vecs[i]);
        end

        // build Pending=0x6 with a write in flight, then reset mid-stream
        @(posedge Clk);
        #1 drive(mk(1,9,32'h9, 0,0,0, 1,0,0,1,1, 0,0,0,0));
        @(negedge Clk);
        pop_check(vecs.size());
        chk("seq clr9 AReady", {31'd0, bus.AReady}, 32'd1);
        @(posedge Clk);
        #1 drive(mk(0,0,0, 0,0,0, 1,0,0,2,1, 0,0,0,0));
        @(posedge Clk);
        #1 drive(mk(1,3,32'h33, 1,4,32'h44, 1,1,0,5,1, 0,0,0,0));
        @(negedge Clk);
        chk("seq Pending 0x6", bus.Pending, 32'h6);
        chk("seq Stall", {31'd0, bus.Stall}, 32'd1);
        chk("seq MReady", {31'd0, bus.MReady}, 32'd1);
        @(posedge Clk);
        #1;
        chk("seq inflight RegWr", {31'd0, bus.RegWr}, 32'd1);
        #1 Reset_n = 1'b0;
        #1;
        chk("mid rst RegWr", {31'd0, bus.RegWr}, 32'd0);
        chk("mid rst RD", {27'd0, bus.RD}, 32'd0);
        chk("mid rst WData", bus.WData, 32'd0);
        chk("mid rst Pending", bus.Pending, 32'd0);
        chk("mid rst ready/stall", {29'd0, bus.AReady, bus.MReady, bus.Stall}, 32'd0);
        @(posedge Clk);
        #1 drive(mk(1,4,32'h44, 0,0,0, 0,0,0,0,0, 0,0,0,0));
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("post rst AReady", {31'd0, bus.AReady}, 32'd1);
        @(posedge Clk);
        #1 drive(idle);
        @(negedge Clk);
        chk("post rst RegWr", {31'd0, bus.RegWr}, 32'd1);
        chk("post rst RD", {27'd0, bus.RD}, 32'd4);
        chk("post rst WData", bus.WData, 32'h44);
        chk("post rst Pending", bus.Pending, 32'd0);
        @(negedge Clk);
        chk("post rst RegWr drop", {31'd0, bus.RegWr}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
